// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states and arbiter defaults.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    localparam int DEF_MAX_DSTREAK = 4;
    localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-cycle watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th.
// The flag is combinational on the current count; the count saturates at TIMEOUT-1.
module arb_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && count_q != LAST)
            count_d = count_q + 1'b1;
    end

    assign expired_o = !clr_i && en_i && (count_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data; data wins until the streak limit forces a fetch.
// Request->hit is at least 2 cycles; requesters are stalled (held) until their hit strobe.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        mem_err
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          dreq, granted, req_held, expired;

    assign dreq     = dREN | dWEN;
    assign granted  = (state_q == IGNT) || (state_q == DGNT);
    assign req_held = (state_q == IGNT) ? iREN : dreq;

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (!granted),
        .en_i      (granted && ramstate != ACCESS),
        .expired_o (expired)
    );

    // RAM side follows the live request: a withdrawn request drops its enable at once.
    always_comb begin
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        mem_err  = (state_q == ERR);
        case (state_q)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ramstate == ACCESS) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramstore = dWEN ? dstore : '0;
                if (dreq && ramstate == ACCESS) begin
                    dhit  = 1'b1;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (dreq && (!iREN || streak_q < STREAK_MAX))
                    state_d = DGNT;
                else if (iREN)
                    state_d = IGNT;
            end
            IGNT, DGNT: begin
                if (!req_held || ramstate == ACCESS)
                    state_d = IDLE;
                else if (ramstate == ERROR || expired)
                    state_d = ERR;
            end
            default: ;
        endcase
        if (!iREN || ihit)
            streak_d = '0;
        else if (dhit && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data priority, streak limit, writes, withdrawal, timeout, reset.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        ihit, dhit, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    int          k, nhits, both;
    logic        saw_hit;
    logic [6:0]  seq;

    initial begin
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h40; daddr = 32'h100; dstore = '0; ramload = 32'h1111_2222; ramstate = ACCESS;
        #1;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_mem_err", mem_err, 0);
        tick();
        iREN = 1'b0; dREN = 1'b0;
        #1;
        chk("rst_held_idle", ramREN, 0);
        RST = 1'b0;

        // Fetch only, two BUSY cycles then ACCESS.
        tick();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #1;
        chk("f_c0_ramREN", ramREN, 0);
        tick(); #1;
        chk("f_c1_ramREN", ramREN, 1);
        chk("f_c1_ramaddr", ramaddr, 32'h40);
        chk("f_c1_ihit", ihit, 0);
        tick(); #1;
        chk("f_c2_ihit", ihit, 0);
        tick();
        ramstate = ACCESS; #1;
        chk("f_c3_ihit", ihit, 1);
        chk("f_c3_iload", iload, 32'h1111_2222);
        chk("f_c3_dhit", dhit, 0);
        tick();
        iREN = 1'b0; ramstate = FREE; #1;
        chk("f_c4_state", dut.state_q, IDLE);
        chk("f_c4_ramREN", ramREN, 0);
        chk("f_c4_ihit", ihit, 0);

        // Simultaneous fetch and data read: data first.
        tick();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        ramstate = ACCESS; ramload = 32'hA5A5_0001; #1;
        chk("p_c0_ramREN", ramREN, 0);
        tick(); #1;
        chk("p_c1_dhit", dhit, 1);
        chk("p_c1_ihit", ihit, 0);
        chk("p_c1_ramaddr", ramaddr, 32'h100);
        chk("p_c1_dload", dload, 32'hA5A5_0001);
        tick();
        dREN = 1'b0; #1;
        chk("p_c2_idle_ramREN", ramREN, 0);
        tick(); #1;
        chk("p_c3_ihit", ihit, 1);
        chk("p_c3_ramaddr", ramaddr, 32'h44);
        tick();
        iREN = 1'b0; #1;

        // Streak limit: six data requests against a held fetch.
        tick();
        iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
        nhits = 0; both = 0; seq = '0;
        for (int c = 0; c < 60 && nhits < 7; c++) begin
            tick(); #1;
            if (ihit && dhit) both++;
            if (ihit || dhit) begin
                seq = {seq[5:0], dhit};
                nhits++;
            end
        end
        chk("s_nhits", nhits, 7);
        chk("s_order", seq, 7'b1111011);
        chk("s_no_double_hit", both, 0);
        tick();
        iREN = 1'b0; dREN = 1'b0; #1;

        // Write: dREN&dWEN together is a write.
        tick();
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = BUSY; #1;
        tick(); #1;
        chk("w_ramWEN", ramWEN, 1);
        chk("w_ramREN", ramREN, 0);
        chk("w_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("w_ramaddr", ramaddr, 32'h200);
        chk("w_busy_dhit", dhit, 0);
        tick();
        ramstate = ACCESS; #1;
        chk("w_dhit", dhit, 1);
        tick();
        dWEN = 1'b0; dREN = 1'b0; #1;

        // Withdrawal with a nonzero streak, then a hung RAM on the following fetch.
        tick();
        iREN = 1'b1; iaddr = 32'h60; dREN = 1'b1; daddr = 32'h180; ramstate = ACCESS; #1;
        tick(); #1;
        chk("x_first_dhit", dhit, 1);
        tick();
        ramstate = BUSY; #1;
        tick(); #1;
        chk("x_dgnt_ramREN", ramREN, 1);
        tick();
        dREN = 1'b0; #1;
        chk("x_drop_dhit", dhit, 0);
        tick(); #1;
        chk("x_abort_state", dut.state_q, IDLE);
        chk("x_streak_kept", dut.streak_q, 1);
        k = 0; saw_hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick(); #1;
            if (mem_err) break;
            if (ihit || dhit) saw_hit = 1'b1;
            k++;
        end
        chk("t_wait_cycles", k, 64);
        chk("t_no_hit", saw_hit, 0);
        ramstate = ACCESS; dREN = 1'b1; #1;
        chk("t_err_ramREN", ramREN, 0);
        chk("t_err_ihit", ihit, 0);
        tick(); tick(); #1;
        chk("t_err_sticky", mem_err, 1);
        chk("t_err_dhit", dhit, 0);
        iREN = 1'b0; dREN = 1'b0;

        // Reset mid-data-grant.
        RST = 1'b1; #1;
        chk("r_clear_err", mem_err, 0);
        tick();
        RST = 1'b0;
        tick();
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; #1;
        tick(); #1;
        chk("r_dgnt_ramREN", ramREN, 1);
        ramstate = ACCESS;
        RST = 1'b1; #1;
        chk("r_async_ramREN", ramREN, 0);
        chk("r_async_ramaddr", ramaddr, 0);
        chk("r_async_dhit", dhit, 0);
        tick();
        RST = 1'b0; dREN = 1'b0; #1;
        chk("r_idle_state", dut.state_q, IDLE);
        tick();
        iREN = 1'b1; iaddr = 32'h80; ramload = 32'hCAFE_F00D; #1;
        tick(); #1;
        chk("r_fetch_ihit", ihit, 1);
        chk("r_fetch_iload", iload, 32'hCAFE_F00D);
        tick();
        iREN = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
